// File: rtl/rr_pkg.sv
// Shared rename/retire constants and the physical register index type.
package rr_pkg;
    localparam int P_REGS       = 128;
    localparam int A_REGS       = 32;
    localparam int P_ADDR_WIDTH = $clog2(P_REGS);
    localparam int INSTR_COUNT  = 2;

    typedef logic [P_ADDR_WIDTH-1:0] preg_t;
endpackage

// File: rtl/free_list_fifo.sv
// Circular free-register buffer: multi-push at tail, fixed-width pop at head,
// and a head pointer that can be restored from a rename checkpoint.
module free_list_fifo #(
    parameter int P_REGS       = rr_pkg::P_REGS,
    parameter int A_REGS       = rr_pkg::A_REGS,
    parameter int P_ADDR_WIDTH = $bits(rr_pkg::preg_t),
    parameter int INSTR_COUNT  = rr_pkg::INSTR_COUNT
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INSTR_COUNT-1:0]                 push,
    input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] push_data,
    input  logic                                   alloc,
    input  logic                                   rec_en,
    input  logic [P_ADDR_WIDTH-1:0]                rec_head,
    output logic [P_ADDR_WIDTH-1:0]                head,
    output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] rd_data,
    output logic                                   ready
);
    localparam int CW = P_ADDR_WIDTH + 1;

    logic [P_ADDR_WIDTH-1:0] mem [P_REGS];
    logic [P_ADDR_WIDTH-1:0] tail, tail_next, head_next;
    logic [CW-1:0]           count, count_next, push_cnt;
    logic                    do_alloc;

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            push_cnt = push_cnt + CW'(push[i]);
        end
    end

    assign ready     = (count >= CW'(INSTR_COUNT));
    assign do_alloc  = alloc & ready & ~rec_en;
    assign tail_next = tail + push_cnt[P_ADDR_WIDTH-1:0];

    always_comb begin
        head_next  = head;
        count_next = count + push_cnt;
        if (rec_en) begin
            // Everything between the restored head and the new tail is free again.
            head_next  = rec_head;
            count_next = {1'b0, tail_next - rec_head};
        end else if (do_alloc) begin
            head_next  = head + P_ADDR_WIDTH'(INSTR_COUNT);
            count_next = count + push_cnt - CW'(INSTR_COUNT);
        end
    end

    always_comb begin
        for (int i = 0; i < INSTR_COUNT; i++) begin
            rd_data[i] = mem[head + P_ADDR_WIDTH'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_REGS; i++) begin
                if (i < P_REGS - A_REGS) mem[i] <= P_ADDR_WIDTH'(A_REGS + i);
                else                     mem[i] <= '0;
            end
            head  <= '0;
            tail  <= P_ADDR_WIDTH'(P_REGS - A_REGS);
            count <= CW'(P_REGS - A_REGS);
        end else begin
            for (int i = 0; i < INSTR_COUNT; i++) begin
                if (push[i]) mem[tail + P_ADDR_WIDTH'(i)] <= push_data[i];
            end
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end
endmodule

// File: rtl/commit_free_list.sv
// Retire selection from the ROB head and return of freed registers to the free list.
// Optional retired-instruction counter enabled by COMMIT_PERF_CNT_EN.
module commit_free_list #(
    parameter int P_REGS       = rr_pkg::P_REGS,
    parameter int A_REGS       = rr_pkg::A_REGS,
    parameter int P_ADDR_WIDTH = $bits(rr_pkg::preg_t),
    parameter int INSTR_COUNT  = rr_pkg::INSTR_COUNT
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INSTR_COUNT-1:0]                 rob_valid,
    input  logic [INSTR_COUNT-1:0]                 rob_exec,
    input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] rob_ppdst,
    output logic [INSTR_COUNT-1:0]                 rob_pop,
    input  logic                                   alloc_req,
    output logic                                   alloc_ready,
    output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] alloc_preg,
    output logic [P_ADDR_WIDTH-1:0]                alloc_head,
    input  logic                                   rec_en,
    input  logic [P_ADDR_WIDTH-1:0]                rec_head
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]                            retired_cnt
`endif
);
    logic [INSTR_COUNT-1:0] pop;
    logic                   run;

    // A slot retires only if every older slot retires too.
    always_comb begin
        pop = '0;
        run = rst_n;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            run    = run & rob_valid[i] & rob_exec[i];
            pop[i] = run;
        end
    end

    assign rob_pop = pop;

    free_list_fifo #(
        .P_REGS       (P_REGS),
        .A_REGS       (A_REGS),
        .P_ADDR_WIDTH (P_ADDR_WIDTH),
        .INSTR_COUNT  (INSTR_COUNT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pop),
        .push_data (rob_ppdst),
        .alloc     (alloc_req),
        .rec_en    (rec_en),
        .rec_head  (rec_head),
        .head      (alloc_head),
        .rd_data   (alloc_preg),
        .ready     (alloc_ready)
    );

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] pop_sum;

    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            pop_sum = pop_sum + 32'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt <= '0;
        else        retired_cnt <= retired_cnt + pop_sum;
    end
`endif
endmodule

// File: tb/tb_commit_free_list.sv
// Self-checking bench for commit_free_list against a pointer/array reference model.
module tb_commit_free_list;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      rob_valid, rob_exec, rob_pop;
    logic [1:0][6:0] rob_ppdst, alloc_preg;
    logic            alloc_req, alloc_ready, rec_en;
    logic [6:0]      alloc_head, rec_head;
`ifdef COMMIT_PERF_CNT_EN
    logic [31:0]     retired_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_mem [128];
    int m_head, m_tail, m_count, m_retired;

    always #5 clk = ~clk;

    commit_free_list dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rob_valid   (rob_valid),
        .rob_exec    (rob_exec),
        .rob_ppdst   (rob_ppdst),
        .rob_pop     (rob_pop),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_preg  (alloc_preg),
        .alloc_head  (alloc_head),
        .rec_en      (rec_en),
        .rec_head    (rec_head)
`ifdef COMMIT_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    function automatic int exp_pops(logic [1:0] v, logic [1:0] e);
        int n = 0;
        for (int i = 0; i < 2; i++) if (n == i && v[i] && e[i]) n++;
        return n;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = (i < 96) ? 32 + i : 0;
        m_head = 0; m_tail = 96; m_count = 96; m_retired = 0;
    endfunction

    function automatic void m_step(int n, logic [1:0][6:0] pd, logic areq, logic rec, logic [6:0] rh);
        int nt;
        for (int i = 0; i < n; i++) m_mem[(m_tail + i) % 128] = int'(pd[i]);
        nt = (m_tail + n) % 128;
        if (rec) begin
            m_head  = int'(rh);
            m_count = (nt - int'(rh) + 128) % 128;
        end else if (areq && m_count >= 2) begin
            m_head  = (m_head + 2) % 128;
            m_count = m_count - 2 + n;
        end else begin
            m_count = m_count + n;
        end
        m_tail = nt;
        m_retired += n;
    endfunction

    task automatic advance();
        m_step(exp_pops(rob_valid, rob_exec), rob_ppdst, alloc_req, rec_en, rec_head);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rob_valid = '0; rob_exec = '0; rob_ppdst = '0;
        alloc_req = 1'b0; rec_en = 1'b0; rec_head = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rob_valid = 2'b11; rob_exec = 2'b11; rob_ppdst = '0;
        alloc_req = 1'b0; rec_en = 1'b0; rec_head = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rob_pop !== 2'b00) begin n_err++; $display("FAIL reset_pop_forced got=%b want=00", rob_pop); end
        rob_valid = '0; rob_exec = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        #1;
        n_cmp++;
        if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", alloc_ready); end
        n_cmp++;
        if (alloc_preg[0] !== 7'd32 || alloc_preg[1] !== 7'd33) begin
            n_err++; $display("FAIL reset_preg got={%0d,%0d} want={33,32}", alloc_preg[1], alloc_preg[0]);
        end
        n_cmp++;
        if (alloc_head !== 7'd0) begin n_err++; $display("FAIL reset_head got=%0d want=0", alloc_head); end
        n_cmp++;
        if (rob_pop !== 2'b00) begin n_err++; $display("FAIL reset_pop got=%b want=00", rob_pop); end
        n_cmp++;
        if (int'(dut.u_fifo.count) != 96 || int'(dut.u_fifo.tail) != 96) begin
            n_err++; $display("FAIL reset_count_tail got=%0d/%0d want=96/96", dut.u_fifo.count, dut.u_fifo.tail);
        end
    endtask

    task automatic test_in_order_retire();
        do_reset();
        rob_valid = 2'b11; rob_exec = 2'b10; rob_ppdst = {7'd5, 7'd4};
        #1;
        n_cmp++;
        if (rob_pop !== 2'b00) begin n_err++; $display("FAIL retire_blocked_pop got=%b want=00", rob_pop); end
        advance();
        n_cmp++;
        if (int'(dut.u_fifo.tail) != 96) begin n_err++; $display("FAIL retire_blocked_tail got=%0d want=96", dut.u_fifo.tail); end
        rob_exec = 2'b11;
        #1;
        n_cmp++;
        if (rob_pop !== 2'b11) begin n_err++; $display("FAIL retire_pop got=%b want=11", rob_pop); end
        advance();
        rob_valid = '0; rob_exec = '0;
        n_cmp++;
        if (dut.u_fifo.mem[96] !== 7'd4 || dut.u_fifo.mem[97] !== 7'd5) begin
            n_err++; $display("FAIL retire_write got=%0d,%0d want=4,5", dut.u_fifo.mem[96], dut.u_fifo.mem[97]);
        end
        n_cmp++;
        if (int'(dut.u_fifo.tail) != 98 || int'(dut.u_fifo.count) != 98) begin
            n_err++; $display("FAIL retire_tail_count got=%0d/%0d want=98/98", dut.u_fifo.tail, dut.u_fifo.count);
        end
    endtask

    task automatic test_drain();
        do_reset();
        alloc_req = 1'b1;
        repeat (48) advance();
        n_cmp++;
        if (int'(dut.u_fifo.count) != 0 || alloc_ready !== 1'b0) begin
            n_err++; $display("FAIL drain_empty got count=%0d ready=%b want 0/0", dut.u_fifo.count, alloc_ready);
        end
        n_cmp++;
        if (alloc_head !== 7'd96) begin n_err++; $display("FAIL drain_head got=%0d want=96", alloc_head); end
        advance();
        alloc_req = 1'b0;
        n_cmp++;
        if (alloc_head !== 7'd96 || int'(dut.u_fifo.count) != 0) begin
            n_err++; $display("FAIL drain_ignored got head=%0d count=%0d want 96/0", alloc_head, dut.u_fifo.count);
        end
    endtask

    task automatic test_alloc_with_commit();
        do_reset();
        alloc_req = 1'b1;
        repeat (47) advance();
        n_cmp++;
        if (int'(dut.u_fifo.count) != 2 || alloc_ready !== 1'b1 || alloc_head !== 7'd94) begin
            n_err++; $display("FAIL sim_pre got count=%0d ready=%b head=%0d want 2/1/94", dut.u_fifo.count, alloc_ready, alloc_head);
        end
        rob_valid = 2'b01; rob_exec = 2'b01; rob_ppdst = {7'd0, 7'd40};
        #1;
        n_cmp++;
        if (rob_pop !== 2'b01) begin n_err++; $display("FAIL sim_pop got=%b want=01", rob_pop); end
        advance();
        rob_valid = '0; rob_exec = '0; alloc_req = 1'b0;
        n_cmp++;
        if (int'(dut.u_fifo.count) != 1 || alloc_ready !== 1'b0) begin
            n_err++; $display("FAIL sim_post got count=%0d ready=%b want 1/0", dut.u_fifo.count, alloc_ready);
        end
        n_cmp++;
        if (dut.u_fifo.mem[96] !== 7'd40 || alloc_head !== 7'd96) begin
            n_err++; $display("FAIL sim_write got mem=%0d head=%0d want 40/96", dut.u_fifo.mem[96], alloc_head);
        end
    endtask

    task automatic test_recovery();
        logic [6:0] ckpt;
        do_reset();
        alloc_req = 1'b1;
        repeat (5) advance();
        ckpt = alloc_head;
        n_cmp++;
        if (ckpt !== 7'd10) begin n_err++; $display("FAIL rec_ckpt got=%0d want=10", ckpt); end
        repeat (3) advance();
        n_cmp++;
        if (alloc_head !== 7'd16) begin n_err++; $display("FAIL rec_pre_head got=%0d want=16", alloc_head); end
        rec_en = 1'b1; rec_head = ckpt;
        advance();
        rec_en = 1'b0; alloc_req = 1'b0;
        n_cmp++;
        if (alloc_head !== 7'd10 || int'(dut.u_fifo.count) != 86) begin
            n_err++; $display("FAIL rec_restore got head=%0d count=%0d want 10/86", alloc_head, dut.u_fifo.count);
        end
        n_cmp++;
        if (alloc_preg[0] !== 7'd42 || alloc_preg[1] !== 7'd43) begin
            n_err++; $display("FAIL rec_preg got={%0d,%0d} want={43,42}", alloc_preg[1], alloc_preg[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_req = 1'b1; rob_valid = 2'b11; rob_exec = 2'b11;
        for (int k = 0; k < 15; k++) begin
            rob_ppdst = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
            advance();
        end
        rob_valid = 2'b01;
        advance();
        n_cmp++;
        if (int'(dut.u_fifo.tail) != 127) begin n_err++; $display("FAIL wrap_pre_tail got=%0d want=127", dut.u_fifo.tail); end
        rob_valid = 2'b11; rob_ppdst = {7'd99, 7'd98};
        advance();
        rob_valid = '0; rob_exec = '0; alloc_req = 1'b0;
        n_cmp++;
        if (dut.u_fifo.mem[127] !== 7'd98 || dut.u_fifo.mem[0] !== 7'd99) begin
            n_err++; $display("FAIL wrap_write got=%0d,%0d want=98,99", dut.u_fifo.mem[127], dut.u_fifo.mem[0]);
        end
        n_cmp++;
        if (int'(dut.u_fifo.tail) != 1 || int'(dut.u_fifo.count) != 95) begin
            n_err++; $display("FAIL wrap_tail_count got=%0d/%0d want=1/95", dut.u_fifo.tail, dut.u_fifo.count);
        end
    endtask

    task automatic test_random();
        int hist[$];
        int n, proj;
        logic [1:0] exp_pop;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rob_valid = 2'($urandom);
            rob_exec  = ((cyc / 100) % 2 == 1) ? 2'b11 : 2'($urandom);
            rob_ppdst = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
            alloc_req = ($urandom_range(0, 3) != 0);
            rec_en    = ($urandom_range(0, 11) == 0) && (hist.size() > 0);
            rec_head  = rec_en ? 7'(hist[$urandom_range(0, hist.size() - 1)]) : 7'($urandom_range(0, 127));
            n = exp_pops(rob_valid, rob_exec);
            if (rec_en) proj = (m_tail + n - int'(rec_head) + 128) % 128;
            else        proj = m_count + n - ((alloc_req && m_count >= 2) ? 2 : 0);
            if (proj > 96) begin
                rob_valid = '0; rec_en = 1'b0;
                n = 0;
            end
            exp_pop = 2'((1 << n) - 1);
            #1;
            n_cmp++;
            if (rob_pop !== exp_pop) begin n_err++; $display("FAIL rnd_pop cyc=%0d got=%b want=%b", cyc, rob_pop, exp_pop); end
            n_cmp++;
            if (alloc_ready !== (m_count >= 2)) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, alloc_ready, m_count >= 2); end
            n_cmp++;
            if (int'(alloc_head) != m_head) begin n_err++; $display("FAIL rnd_head cyc=%0d got=%0d want=%0d", cyc, alloc_head, m_head); end
            n_cmp++;
            if (int'(alloc_preg[0]) != m_mem[m_head] || int'(alloc_preg[1]) != m_mem[(m_head + 1) % 128]) begin
                n_err++; $display("FAIL rnd_preg cyc=%0d got={%0d,%0d} want={%0d,%0d}", cyc,
                                  alloc_preg[1], alloc_preg[0], m_mem[(m_head + 1) % 128], m_mem[m_head]);
            end
            hist.push_back(m_head);
            if (hist.size() > 6) void'(hist.pop_front());
            advance();
            n_cmp++;
            if (int'(dut.u_fifo.count) != m_count || int'(dut.u_fifo.tail) != m_tail) begin
                n_err++; $display("FAIL rnd_count_tail cyc=%0d got=%0d/%0d want=%0d/%0d", cyc,
                                  dut.u_fifo.count, dut.u_fifo.tail, m_count, m_tail);
            end
`ifdef COMMIT_PERF_CNT_EN
            n_cmp++;
            if (int'(retired_cnt) != m_retired) begin
                n_err++; $display("FAIL rnd_retired cyc=%0d got=%0d want=%0d", cyc, retired_cnt, m_retired);
            end
`endif
        end
        rob_valid = '0; rob_exec = '0; alloc_req = 1'b0; rec_en = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        alloc_req = 1'b1; rob_valid = 2'b11; rob_exec = 2'b11; rob_ppdst = {7'd7, 7'd6};
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rob_pop !== 2'b00 || alloc_head !== 7'd0 || int'(dut.u_fifo.count) != 96) begin
            n_err++; $display("FAIL midreset got pop=%b head=%0d count=%0d want 00/0/96", rob_pop, alloc_head, dut.u_fifo.count);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_in_order_retire();
        test_drain();
        test_alloc_with_commit();
        test_recovery();
        test_wrap();
        test_random();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/commit_free_list.md
COMMIT_FREE_LIST -- requirements
Module: commit_free_list

Interface
REQ-001 SHALL have parameter P_REGS, default 128; number of physical registers, a power of two.
REQ-002 SHALL have parameter A_REGS, default 32; number of architectural registers, which are initially mapped.
REQ-003 SHALL have parameter P_ADDR_WIDTH, default 7; equals $clog2(P_REGS).
REQ-004 SHALL have parameter INSTR_COUNT, default 2; commit width and allocation width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-007 SHALL have port rob_valid, input, INSTR_COUNT; ROB head slot i occupied.
REQ-008 SHALL have port rob_exec, input, INSTR_COUNT; ROB head slot i executed.
REQ-009 SHALL have port rob_ppdst, input, INSTR_COUNT x P_ADDR_WIDTH; previous physical destination of head slot i.
REQ-010 SHALL have port rob_pop, output, INSTR_COUNT; retire head slot i.
REQ-011 SHALL have port alloc_req, input, 1; rename takes INSTR_COUNT registers.
REQ-012 SHALL have port alloc_ready, output, 1; at least INSTR_COUNT registers are free.
REQ-013 SHALL have port alloc_preg, output, INSTR_COUNT x P_ADDR_WIDTH; registers offered for allocation.
REQ-014 SHALL have port alloc_head, output, P_ADDR_WIDTH; current read pointer, checkpointed by rename.
REQ-015 SHALL have port rec_en, input, 1; misprediction recovery.
REQ-016 SHALL have port rec_head, input, P_ADDR_WIDTH; checkpointed alloc_head to restore.

Function
REQ-017 SHALL compute rob_pop[0] = rob_valid[0] & rob_exec[0], and rob_pop[i] = rob_pop[i-1] & rob_valid[i] & rob_exec[i]; pops are always a contiguous prefix.
REQ-018 SHALL generate rob_pop combinationally, with zero-cycle latency.
REQ-019 SHALL hold free registers in a P_REGS-entry circular buffer with a head pointer, a tail pointer and a count register.
REQ-020 SHALL drive alloc_preg[i] = mem[head+i mod P_REGS] combinationally.
REQ-021 SHALL drive alloc_head = head.
REQ-022 SHALL drive alloc_ready = (count >= INSTR_COUNT).
REQ-023 SHALL, for each i with rob_pop[i] set, write rob_ppdst[i] to mem[tail+i mod P_REGS] at the clock edge, and advance tail by popcount(rob_pop).
REQ-024 SHALL, when alloc_req & alloc_ready & !rec_en, advance head by INSTR_COUNT.
REQ-025 SHALL treat alloc_req while alloc_ready is low as a no-op.
REQ-026 SHALL, when allocation and commit occur in the same cycle, set count_next = count - INSTR_COUNT + popcount(rob_pop).
REQ-027 SHALL, on rec_en, set head to rec_head and ignore alloc_req that cycle; commits in that cycle still push.
REQ-028 SHALL, on rec_en, set count = (tail_next - rec_head) mod P_REGS.
REQ-029 SHALL have all pointers wrap modulo P_REGS with no explicit limit check.
REQ-030 SHALL never hold more than P_REGS - A_REGS entries; because of that bound, overflow is impossible and no full flag exists.

Reset
REQ-031 SHALL, while rst_n is low, initialise mem[i] = A_REGS+i for i < P_REGS-A_REGS, with head = 0, tail = P_REGS-A_REGS and count = P_REGS-A_REGS.
REQ-032 SHALL force rob_pop to 0 while rst_n is low.
REQ-033 SHALL come out of reset with alloc_ready = 1, alloc_head = 0 and alloc_preg = {A_REGS+1, A_REGS}.
REQ-034 SHALL, when reset is asserted mid-operation, discard all pending pushes and allocations immediately.

Configuration
REQ-035 SHALL, with COMMIT_PERF_CNT_EN defined, add output retired_cnt, 32 bits; reset to 0, incremented by popcount(rob_pop) each cycle, wrapping at 2^32.
REQ-036 SHALL, with COMMIT_PERF_CNT_EN undefined, omit the port and the counter entirely; behaviour is otherwise identical.

Structure
REQ-037 SHALL take P_REGS, A_REGS, INSTR_COUNT and a preg_t typedef (logic [P_ADDR_WIDTH-1:0]) from the shared package rr_pkg.
REQ-038 SHALL place the circular buffer, its pointers and its count in sub-module free_list_fifo (multi-push, multi-pop, restorable head); commit selection stays in the top level.

Verification
REQ-039 SHALL check reset: release rst_n -> alloc_ready=1, alloc_preg={33,32}, alloc_head=0, rob_pop=0.
REQ-040 SHALL check in-order retire: rob_valid=11, rob_exec=10 -> rob_pop=00 and no push; then rob_exec=11 with rob_ppdst={5,4} -> rob_pop=11, and 4 and 5 are written at tail 96 and 97.
REQ-041 SHALL check drain: 48 back-to-back allocations with no commits -> count=0 and alloc_ready=0; alloc_req is then ignored and head stays at 96.
REQ-042 SHALL check simultaneous allocation and commit at count=2 with rob_pop=01 -> count=1 next cycle and alloc_ready=0.
REQ-043 SHALL check recovery: checkpoint alloc_head=10, allocate 3 times (head=16), then rec_en with rec_head=10 and alloc_req=1 -> head=10, count restored, no allocation.
REQ-044 SHALL check wrap-around: tail=127 with a 2-entry commit -> entries written at 127 and 0, and tail=1.
